sram_arbiter: RTL and testbench

//  Shares the single off-chip 1Mx16 async SRAM between the recorder (write port)
//  and the DSP/player (read port) behind Top. Each port uses a req/ack handshake.
//  The block arbitrates round-robin and sequences CE_N/OE_N/WE_N/LB_N/UB_N

---
 rtl/sram_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of one async 1Mx16 SRAM between a write
// port (recorder) and a read port (DSP/player). Strobes, address, data-bus
// enable and acks are all registered; each is computed from the next state
// so that it lines up with the state it belongs to.
module sram_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_HOLD = 3'd2,
    S_RD      = 3'd3,
    S_RD_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prio_wr_q, prio_wr_d;   // 1: write wins a tie
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_n_q, we_n_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              bls_n_q, bls_n_d;       // shared LB_N/UB_N: always full word
  logic              dq_oe_q, dq_oe_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic              busy_q, busy_d;

  // Next-state, arbitration, latching of request fields and read capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_wr_d = prio_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (i_wr_req && (!i_rd_req || prio_wr_q)) begin
          state_d   = S_WR;
          cnt_d     = {CNT_W{1'b0}};
          prio_wr_d = 1'b0;
          addr_d    = i_wr_addr;
          wdata_d   = i_wr_data;
        end else if (i_rd_req) begin
          state_d   = S_RD;
          cnt_d     = {CNT_W{1'b0}};
          prio_wr_d = 1'b1;
          addr_d    = i_rd_addr;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_WR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_HOLD: begin
        state_d = S_IDLE;
      end
      S_RD: begin
        if (cnt_q == CNT_LAST) begin
          // OE_N is still low on this edge, so the SRAM is driving the bus.
          state_d = S_RD_DONE;
          rdata_d = io_SRAM_DQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobe, bus-enable and ack values for the state being entered.
  always_comb begin
    we_n_d   = 1'b1;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    bls_n_d  = 1'b1;
    dq_oe_d  = 1'b0;
    wr_ack_d = 1'b0;
    rd_ack_d = 1'b0;
    busy_d   = 1'b1;
    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_WR: begin
        ce_n_d  = 1'b0;
        bls_n_d = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      S_WR_HOLD: begin
        // WE_N rises first; data, address and CE_N stay for hold time.
        ce_n_d   = 1'b0;
        bls_n_d  = 1'b0;
        dq_oe_d  = 1'b1;
        wr_ack_d = 1'b1;
      end
      S_RD: begin
        ce_n_d  = 1'b0;
        bls_n_d = 1'b0;
        oe_n_d  = 1'b0;
      end
      S_RD_DONE: begin
        ce_n_d   = 1'b0;
        bls_n_d  = 1'b0;
        rd_ack_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset parks the SRAM deselected with bus released.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      prio_wr_q <= 1'b1;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      rdata_q   <= {DATA_W{1'b0}};
      we_n_q    <= 1'b1;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      bls_n_q   <= 1'b1;
      dq_oe_q   <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prio_wr_q <= prio_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      we_n_q    <= we_n_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      bls_n_q   <= bls_n_d;
      dq_oe_q   <= dq_oe_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign io_SRAM_DQ  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_LB_N = bls_n_q;
  assign o_SRAM_UB_N = bls_n_q;
  assign o_wr_ack    = wr_ack_q;
  assign o_rd_ack    = rd_ack_q;
  assign o_rd_data   = rdata_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: two arbiters (ACCESS_CYCLES=2 and =1), each with a small
// behavioural SRAM. Stimulus pushes expected acks into queues; monitors pop
// and compare whenever an ack appears, and police the bus protocol.
module tb_sram_arbiter;

  localparam logic [7:0] K_W = 8'h57;
  localparam logic [7:0] K_R = 8'h52;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Free-running cycle count for latency/period measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: ACCESS_CYCLES = 2 ----------------
  logic        a_wr_req = 1'b0, a_rd_req = 1'b0;
  logic [19:0] a_wr_addr = 20'h0, a_rd_addr = 20'h0;
  logic [15:0] a_wr_data = 16'h0;
  logic        a_wr_ack, a_rd_ack, a_busy;
  logic [15:0] a_rd_data;
  logic [19:0] a_addr;
  wire  [15:0] a_dq;
  logic        a_we_n, a_ce_n, a_oe_n, a_lb_n, a_ub_n;
  logic [15:0] mem_a [0:1023];

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(2)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(a_wr_req), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data), .o_wr_ack(a_wr_ack),
    .i_rd_req(a_rd_req), .i_rd_addr(a_rd_addr), .o_rd_ack(a_rd_ack), .o_rd_data(a_rd_data),
    .o_busy(a_busy), .o_SRAM_ADDR(a_addr), .io_SRAM_DQ(a_dq),
    .o_SRAM_WE_N(a_we_n), .o_SRAM_CE_N(a_ce_n), .o_SRAM_OE_N(a_oe_n),
    .o_SRAM_LB_N(a_lb_n), .o_SRAM_UB_N(a_ub_n)
  );

  assign a_dq = (!a_ce_n && !a_oe_n && a_we_n) ? mem_a[a_addr[9:0]] : 16'hzzzz;

  // SRAM A latches data on the rising edge of WE_N.
  always @(posedge a_we_n) if (!a_ce_n && !rst) mem_a[a_addr[9:0]] <= a_dq;

  // ---------------- DUT B: ACCESS_CYCLES = 1 ----------------
  logic        b_wr_req = 1'b0, b_rd_req = 1'b0;
  logic [19:0] b_wr_addr = 20'h0, b_rd_addr = 20'h0;
  logic [15:0] b_wr_data = 16'h0;
  logic        b_wr_ack, b_rd_ack, b_busy;
  logic [15:0] b_rd_data;
  logic [19:0] b_addr;
  wire  [15:0] b_dq;
  logic        b_we_n, b_ce_n, b_oe_n, b_lb_n, b_ub_n;
  logic [15:0] mem_b [0:1023];

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(1)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(b_wr_req), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data), .o_wr_ack(b_wr_ack),
    .i_rd_req(b_rd_req), .i_rd_addr(b_rd_addr), .o_rd_ack(b_rd_ack), .o_rd_data(b_rd_data),
    .o_busy(b_busy), .o_SRAM_ADDR(b_addr), .io_SRAM_DQ(b_dq),
    .o_SRAM_WE_N(b_we_n), .o_SRAM_CE_N(b_ce_n), .o_SRAM_OE_N(b_oe_n),
    .o_SRAM_LB_N(b_lb_n), .o_SRAM_UB_N(b_ub_n)
  );

  assign b_dq = (!b_ce_n && !b_oe_n && b_we_n) ? mem_b[b_addr[9:0]] : 16'hzzzz;

  // SRAM B latches data on the rising edge of WE_N.
  always @(posedge b_we_n) if (!b_ce_n && !rst) mem_b[b_addr[9:0]] <= b_dq;

  // ---------------- scoreboard queues ----------------
  logic [35:0] a_wr_exp[$];
  logic [15:0] a_rd_exp[$];
  logic [7:0]  a_order[$];
  logic [35:0] b_wr_exp[$];
  logic [15:0] b_rd_exp[$];

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor A: match acks against queued expectations; police the bus.
  initial forever begin
    logic [35:0] e;
    logic [15:0] d;
    logic [7:0]  k;
    @(negedge clk);
    if (a_wr_ack) begin
      if (a_order.size() == 0) chk("a_unexpected_wr_ack", 36'(1), 36'(0));
      else begin k = a_order.pop_front(); chk("a_order_wr", 36'(k), 36'(K_W)); end
      if (a_wr_exp.size() == 0) chk("a_wr_q_underflow", 36'(1), 36'(0));
      else begin
        e = a_wr_exp.pop_front();
        chk("a_wr_addr", 36'(a_addr), 36'(e[35:16]));
        chk("a_wr_dq_hold", 36'(a_dq), 36'(e[15:0]));
      end
    end
    if (a_rd_ack) begin
      if (a_order.size() == 0) chk("a_unexpected_rd_ack", 36'(1), 36'(0));
      else begin k = a_order.pop_front(); chk("a_order_rd", 36'(k), 36'(K_R)); end
      if (a_rd_exp.size() == 0) chk("a_rd_q_underflow", 36'(1), 36'(0));
      else begin d = a_rd_exp.pop_front(); chk("a_rd_data", 36'(a_rd_data), 36'(d)); end
      chk("a_dq_z_rd_done", 36'(a_dq === 16'hzzzz), 36'(1));
    end
    if (!rst) begin
      chk("a_we_oe_overlap", 36'(!(!a_we_n && !a_oe_n)), 36'(1));
      if (a_ce_n) chk("a_dq_z_idle", 36'(a_dq === 16'hzzzz), 36'(1));
    end
  end

  // Monitor B: same checks for the single-cycle-access arbiter.
  initial forever begin
    logic [35:0] e;
    logic [15:0] d;
    @(negedge clk);
    if (b_wr_ack) begin
      if (b_wr_exp.size() == 0) chk("b_unexpected_wr_ack", 36'(1), 36'(0));
      else begin
        e = b_wr_exp.pop_front();
        chk("b_wr_addr", 36'(b_addr), 36'(e[35:16]));
        chk("b_wr_dq_hold", 36'(b_dq), 36'(e[15:0]));
      end
    end
    if (b_rd_ack) begin
      if (b_rd_exp.size() == 0) chk("b_unexpected_rd_ack", 36'(1), 36'(0));
      else begin d = b_rd_exp.pop_front(); chk("b_rd_data", 36'(b_rd_data), 36'(d)); end
      chk("b_dq_z_rd_done", 36'(b_dq === 16'hzzzz), 36'(1));
    end
    if (!rst) begin
      chk("b_we_oe_overlap", 36'(!(!b_we_n && !b_oe_n)), 36'(1));
      if (b_ce_n) chk("b_dq_z_idle", 36'(b_dq === 16'hzzzz), 36'(1));
    end
  end

  // Write requester on A: n accesses with req held throughout, dropped on last ack.
  task automatic a_wr_burst(input int n, input logic [19:0] a0, input logic [15:0] d0);
    logic got;
    for (int k = 0; k < n; k++) begin
      a_wr_addr = a0 + 20'(k);
      a_wr_data = d0 + 16'(k);
      a_wr_req  = 1'b1;
      a_wr_exp.push_back({a_wr_addr, a_wr_data});
      got = 1'b0;
      for (int c = 0; c < 30 && !got; c++) begin
        @(negedge clk);
        got = a_wr_ack;
      end
      if (!got) chk("a_wr_ack_timeout", 36'(got), 36'(1));
    end
    a_wr_req = 1'b0;
  endtask

  // Read requester on A: n accesses, each expecting e0+k from address a0+k.
  task automatic a_rd_burst(input int n, input logic [19:0] a0, input logic [15:0] e0);
    logic got;
    for (int k = 0; k < n; k++) begin
      a_rd_addr = a0 + 20'(k);
      a_rd_req  = 1'b1;
      a_rd_exp.push_back(e0 + 16'(k));
      got = 1'b0;
      for (int c = 0; c < 30 && !got; c++) begin
        @(negedge clk);
        got = a_rd_ack;
      end
      if (!got) chk("a_rd_ack_timeout", 36'(got), 36'(1));
    end
    a_rd_req = 1'b0;
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int t_ack [2];
    int n_ack;

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_strobes", 36'({a_we_n, a_ce_n, a_oe_n, a_lb_n, a_ub_n}), 36'(5'b11111));
    chk("rst_addr", 36'(a_addr), 36'(0));
    chk("rst_dq_z", 36'(a_dq === 16'hzzzz), 36'(1));
    chk("rst_acks_busy", 36'({a_wr_ack, a_rd_ack, a_busy}), 36'(0));
    chk("rst_rd_data", 36'(a_rd_data), 36'(0));
    rst = 1'b0;
    @(negedge clk);

    // ---- 1: write 0x12345 <= 0xBEEF ----
    a_order.push_back(K_W);
    a_wr_exp.push_back({20'h12345, 16'hBEEF});
    a_wr_addr = 20'h12345; a_wr_data = 16'hBEEF; a_wr_req = 1'b1;
    @(negedge clk);
    chk("t1_c1_strobes", 36'({a_we_n, a_ce_n, a_oe_n, a_lb_n, a_ub_n}), 36'(5'b00100));
    chk("t1_c1_addr", 36'(a_addr), 36'(20'h12345));
    chk("t1_c1_dq", 36'(a_dq), 36'(16'hBEEF));
    chk("t1_c1_ack_busy", 36'({a_wr_ack, a_busy}), 36'(2'b01));
    @(negedge clk);
    chk("t1_c2_we_ack", 36'({a_we_n, a_wr_ack}), 36'(2'b00));
    @(negedge clk);
    chk("t1_c3_we_ack_ce", 36'({a_we_n, a_wr_ack, a_ce_n}), 36'(3'b110));
    a_wr_req = 1'b0;
    @(negedge clk);
    chk("t1_c4_dq_z", 36'(a_dq === 16'hzzzz), 36'(1));
    chk("t1_c4_ack_ce_busy", 36'({a_wr_ack, a_ce_n, a_busy}), 36'(3'b010));

    // ---- 2: read back 0x12345 ----
    a_order.push_back(K_R);
    a_rd_exp.push_back(16'hBEEF);
    a_rd_addr = 20'h12345; a_rd_req = 1'b1;
    @(negedge clk);
    chk("t2_c1_strobes", 36'({a_we_n, a_ce_n, a_oe_n}), 36'(3'b100));
    chk("t2_c1_ack", 36'(a_rd_ack), 36'(0));
    @(negedge clk);
    chk("t2_c2_oe_ack", 36'({a_oe_n, a_rd_ack}), 36'(2'b00));
    @(negedge clk);
    chk("t2_c3_oe_ack", 36'({a_oe_n, a_rd_ack}), 36'(2'b11));
    a_rd_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t2_data_held", 36'(a_rd_data), 36'(16'hBEEF));
    chk("t2_ack_low", 36'(a_rd_ack), 36'(0));

    // ---- 3: simultaneous requests after reset: write first ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a_order.push_back(K_W);
    a_order.push_back(K_R);
    t0 = cyc;
    fork
      a_wr_burst(1, 20'h00010, 16'h1111);
      a_rd_burst(1, 20'h12345, 16'hBEEF);
    join
    chk("t3_both_within_8", 36'((cyc - t0) <= 8), 36'(1));
    @(negedge clk);

    // ---- 4: both held for 6 accesses: W,R,W,R,W,R ----
    for (int k = 0; k < 3; k++) begin
      a_order.push_back(K_W);
      a_order.push_back(K_R);
    end
    fork
      a_wr_burst(3, 20'h00100, 16'hC000);
      a_rd_burst(3, 20'h00100, 16'hC000);
    join
    repeat (2) @(negedge clk);

    // ---- 5: reset in the middle of a write ----
    a_wr_addr = 20'h00300; a_wr_data = 16'hDEAD; a_wr_req = 1'b1;
    @(negedge clk);
    chk("t5_in_wr", 36'(a_we_n), 36'(0));
    rst = 1'b1;
    #1;
    chk("t5_strobes_off", 36'({a_we_n, a_ce_n, a_oe_n, a_lb_n, a_ub_n}), 36'(5'b11111));
    chk("t5_dq_z", 36'(a_dq === 16'hzzzz), 36'(1));
    chk("t5_busy_addr_data", 36'({a_busy, a_addr, a_rd_data}), 36'(0));
    a_wr_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5_no_ack", 36'({a_wr_ack, a_rd_ack}), 36'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    a_order.push_back(K_W);
    a_order.push_back(K_R);
    a_wr_burst(1, 20'h00200, 16'h5A5A);
    @(negedge clk);
    a_rd_burst(1, 20'h00200, 16'h5A5A);
    @(negedge clk);

    // ---- 6: ACCESS_CYCLES=1 at 0xFFFFF, 3-cycle period ----
    b_wr_exp.push_back({20'hFFFFF, 16'hA5A5});
    b_wr_exp.push_back({20'hFFFFF, 16'hA5A5});
    b_wr_addr = 20'hFFFFF; b_wr_data = 16'hA5A5; b_wr_req = 1'b1;
    t0 = cyc; n_ack = 0;
    for (int c = 0; c < 12 && n_ack < 2; c++) begin
      @(negedge clk);
      if (b_wr_ack) begin t_ack[n_ack] = cyc; n_ack++; end
    end
    b_wr_req = 1'b0;
    chk("t6_wr_ack_count", 36'(n_ack), 36'(2));
    if (n_ack == 2) begin
      chk("t6_wr_latency", 36'(t_ack[0] - t0), 36'(2));
      chk("t6_wr_period", 36'(t_ack[1] - t_ack[0]), 36'(3));
    end
    @(negedge clk);
    b_rd_exp.push_back(16'hA5A5);
    b_rd_exp.push_back(16'hA5A5);
    b_rd_addr = 20'hFFFFF; b_rd_req = 1'b1;
    t0 = cyc; n_ack = 0;
    for (int c = 0; c < 12 && n_ack < 2; c++) begin
      @(negedge clk);
      if (b_rd_ack) begin t_ack[n_ack] = cyc; n_ack++; end
    end
    b_rd_req = 1'b0;
    chk("t6_rd_ack_count", 36'(n_ack), 36'(2));
    if (n_ack == 2) begin
      chk("t6_rd_latency", 36'(t_ack[0] - t0), 36'(2));
      chk("t6_rd_period", 36'(t_ack[1] - t_ack[0]), 36'(3));
    end
    repeat (2) @(negedge clk);
    chk("t6_rd_data_held", 36'(b_rd_data), 36'(16'hA5A5));

    // ---- drain: every queued expectation must have been consumed ----
    repeat (2) @(negedge clk);
    chk("a_wr_q_left", 36'(a_wr_exp.size()), 36'(0));
    chk("a_rd_q_left", 36'(a_rd_exp.size()), 36'(0));
    chk("a_order_q_left", 36'(a_order.size()), 36'(0));
    chk("b_wr_q_left", 36'(b_wr_exp.size()), 36'(0));
    chk("b_rd_q_left", 36'(b_rd_exp.size()), 36'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
